// File: rtl/stoch_sobel_core.sv
// Stochastic-computing Sobel gradient core: one XOR of two correlated
// comparator streams per cycle, counted over a 256-cycle job.
module stoch_sobel_core #(
  parameter int         DIR    = 0,
  parameter logic [7:0] SEED_R = 8'h01,
  parameter logic [7:0] SEED_S = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pixel_1_bin,
  input  logic [7:0] pixel_2_bin,
  input  logic [7:0] pixel_3_bin,
  input  logic [7:0] pixel_4_bin,
  input  logic [7:0] pixel_6_bin,
  input  logic [7:0] pixel_7_bin,
  input  logic [7:0] pixel_8_bin,
  input  logic [7:0] pixel_9_bin,
  output logic [7:0] z_bin,
  output logic       done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SR = (SEED_R == 8'h00) ? 8'h01 : SEED_R;
  localparam logic [7:0] SS = (SEED_S == 8'h00) ? 8'h01 : SEED_S;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic       armed;
  logic [7:0] px1, px2, px3, px4, px6, px7, px8, px9;
  logic [7:0] lfsr_r, lfsr_s;
  logic [8:0] ones, cyc;
  logic [7:0] a_pix, b_pix;
  logic       stream;

  // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_pix = px3;
    b_pix = px1;
    if (DIR == 0) begin
      case (lfsr_s[1:0])
        2'd0:    begin a_pix = px3; b_pix = px1; end
        2'd1,
        2'd2:    begin a_pix = px6; b_pix = px4; end
        default: begin a_pix = px9; b_pix = px7; end
      endcase
    end else begin
      case (lfsr_s[1:0])
        2'd0:    begin a_pix = px7; b_pix = px1; end
        2'd1,
        2'd2:    begin a_pix = px8; b_pix = px2; end
        default: begin a_pix = px9; b_pix = px3; end
      endcase
    end
    // Both sides share lfsr_r, so XOR of the streams yields |A-B|.
    stream = (a_pix > lfsr_r) ^ (b_pix > lfsr_r);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the pixel latches are reset too, so an aborted job leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      armed  <= 1'b0;
      done   <= 1'b0;
      z_bin  <= 8'h00;
      ones   <= 9'd0;
      cyc    <= 9'd0;
      lfsr_r <= SR;
      lfsr_s <= SS;
      {px1, px2, px3, px4, px6, px7, px8, px9} <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A launch needs start seen high first, so a held-low start never relaunches.
          if (start) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed  <= 1'b0;
            state  <= RUN;
            px1    <= pixel_1_bin;
            px2    <= pixel_2_bin;
            px3    <= pixel_3_bin;
            px4    <= pixel_4_bin;
            px6    <= pixel_6_bin;
            px7    <= pixel_7_bin;
            px8    <= pixel_8_bin;
            px9    <= pixel_9_bin;
            lfsr_r <= SR;
            lfsr_s <= SS;
            ones   <= 9'd0;
            cyc    <= 9'd0;
          end
        end
        RUN: begin
          // Cycles 0..255 accumulate; the extra step at 256 publishes the result.
          if (cyc == 9'd256) begin
            state <= DONE;
            done  <= 1'b1;
            z_bin <= ones[8] ? 8'hFF : ones[7:0];
          end else begin
            ones   <= ones + {8'd0, stream};
            cyc    <= cyc + 9'd1;
            lfsr_r <= lfsr_next(lfsr_r);
            lfsr_s <= lfsr_next(lfsr_s);
          end
        end
        DONE: begin
          if (start) begin
            state <= IDLE;
            done  <= 1'b0;
            armed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_sobel_core.sv
// Bench for stoch_sobel_core: a job-level reference model checked every
// cycle against an X-gradient and a Y-gradient instance, plus literal pins.
module tb_stoch_sobel_core;

  typedef logic [7:0] win_t [1:9];

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  win_t       pix;
  logic [7:0] z_x, z_y;
  logic       done_x, done_y;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stoch_sobel_core #(.DIR(0), .SEED_R(8'h01), .SEED_S(8'hA5)) dut_x (
    .clk(clk), .reset(reset), .start(start),
    .pixel_1_bin(pix[1]), .pixel_2_bin(pix[2]), .pixel_3_bin(pix[3]),
    .pixel_4_bin(pix[4]), .pixel_6_bin(pix[6]), .pixel_7_bin(pix[7]),
    .pixel_8_bin(pix[8]), .pixel_9_bin(pix[9]),
    .z_bin(z_x), .done(done_x)
  );

  stoch_sobel_core #(.DIR(1), .SEED_R(8'h00), .SEED_S(8'h3C)) dut_y (
    .clk(clk), .reset(reset), .start(start),
    .pixel_1_bin(pix[1]), .pixel_2_bin(pix[2]), .pixel_3_bin(pix[3]),
    .pixel_4_bin(pix[4]), .pixel_6_bin(pix[6]), .pixel_7_bin(pix[7]),
    .pixel_8_bin(pix[8]), .pixel_9_bin(pix[9]),
    .z_bin(z_y), .done(done_y)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference result: walk both pseudo-random sequences and count |A-B| ones.
  function automatic int ref_z(input int dir, input logic [7:0] sr,
                               input logic [7:0] ss, input win_t w);
    logic [7:0] r, s, a, b;
    int cnt;
    r = (sr == 0) ? 8'h01 : sr;
    s = (ss == 0) ? 8'h01 : ss;
    cnt = 0;
    for (int t = 0; t < 256; t++) begin
      case (s[1:0])
        2'd0:    begin a = dir ? w[7] : w[3]; b = dir ? w[1] : w[1]; end
        2'd1,
        2'd2:    begin a = dir ? w[8] : w[6]; b = dir ? w[2] : w[4]; end
        default: begin a = w[9];              b = dir ? w[3] : w[7]; end
      endcase
      cnt += int'((a > r) != (b > r));
      r = {r[6:0], ^(r & 8'hB8)};
      s = {s[6:0], ^(s & 8'hB8)};
    end
    return (cnt > 255) ? 255 : cnt;
  endfunction

  // Job-level model: launch needs start high then low, done 257 edges later.
  logic m_busy, m_armed, m_done;
  int   m_left, m_zx, m_zy;
  win_t m_pix;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_armed <= 1'b0; m_done <= 1'b0;
      m_left <= 0; m_zx <= 0; m_zy <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_zx   <= ref_z(0, 8'h01, 8'hA5, m_pix);
        m_zy   <= ref_z(1, 8'h00, 8'h3C, m_pix);
      end
      m_left <= m_left - 1;
    end else if (start) begin
      m_armed <= 1'b1;
      m_done  <= 1'b0;
    end else if (!m_done && m_armed) begin
      m_pix   <= pix;
      m_left  <= 257;
      m_busy  <= 1'b1;
      m_armed <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("done_x", int'(done_x), int'(m_done));
      check("done_y", int'(done_y), int'(m_done));
      check("z_x", int'(z_x), m_zx);
      check("z_y", int'(z_y), m_zy);
    end
  end

  task automatic set_win(input logic [7:0] p1, p2, p3, p4, p6, p7, p8, p9);
    pix[1] = p1; pix[2] = p2; pix[3] = p3; pix[4] = p4; pix[5] = 8'h00;
    pix[6] = p6; pix[7] = p7; pix[8] = p8; pix[9] = p9;
  endtask

  // start high one cycle, launch, disturb pixels/start mid-run, end at done.
  task automatic run_job(input logic [7:0] p1, p2, p3, p4, p6, p7, p8, p9);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    set_win(p1, p2, p3, p4, p6, p7, p8, p9);
    start = 1'b0;
    repeat (10) @(negedge clk);
    set_win(8'hC3, 8'h11, 8'h7E, 8'h02, 8'hF0, 8'h99, 8'h40, 8'h0D);
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (243) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b1;
    set_win(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_done_x", int'(done_x), 0);
    check("rst_z_x", int'(z_x), 0);
    check("rst_done_y", int'(done_y), 0);
    check("rst_z_y", int'(z_y), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Uniform window: no gradient.
    run_job(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    check("pin_uniform_model", m_zx, 0);
    check("pin_uniform_dut", int'(z_x), 0);
    check("pin_uniform_done", int'(done_x), 1);

    // Full-scale step, both polarities, saturates to 255.
    run_job(8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255);
    check("pin_step_model", m_zx, 255);
    check("pin_step_dut", int'(z_x), 255);
    run_job(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0);
    check("pin_step_swap_dut", int'(z_x), 255);

    // Half-scale step.
    run_job(8'd0, 8'd0, 8'd128, 8'd0, 8'd128, 8'd0, 8'd0, 8'd128);
    check("pin_half_model", m_zx, 128);
    check("pin_half_dut", int'(z_x), 128);

    // Horizontal edge: Y sees 128, column-matched X sees 0.
    run_job(8'd0, 8'd0, 8'd0, 8'd77, 8'd77, 8'd128, 8'd128, 8'd128);
    check("pin_y_model", m_zy, 128);
    check("pin_y_dut", int'(z_y), 128);
    check("pin_x_flat_dut", int'(z_x), 0);

    // Hold start low after done: no relaunch, result held.
    repeat (12) @(negedge clk);
    check("hold_done", int'(done_x), 1);
    check("hold_z", int'(z_y), 128);

    // Mixed window, checked against the model only.
    run_job(8'd10, 8'd200, 8'd90, 8'd33, 8'd250, 8'd140, 8'd5, 8'd60);
    check("mixed_done", int'(done_y), 1);

    // Reset in the middle of a job.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    set_win(8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255);
    start = 1'b0;
    repeat (100) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_done_x", int'(done_x), 0);
    check("abort_z_x", int'(z_x), 0);
    check("abort_done_y", int'(done_y), 0);
    check("abort_z_y", int'(z_y), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("no_relaunch_after_reset", int'(done_x), 0);

    run_job(8'd20, 8'd30, 8'd180, 8'd40, 8'd160, 8'd50, 8'd60, 8'd170);
    check("post_reset_done", int'(done_x), 1);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("release_done", int'(done_x), 0);
    check("release_z_held", int'(z_x), m_zx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stoch_sobel_core.md
STOCH_SOBEL_CORE -- requirements
Module: stoch_sobel_core

Interface
REQ-001 Parameter: DIR, default 0, gradient direction (0 = Sobel X, 1 = Sobel Y).
REQ-002 Parameter: SEED_R, default 8'h01, pixel-comparator LFSR seed; value 0 SHALL be replaced by 8'h01.
REQ-003 Parameter: SEED_S, default 8'hA5, mux-select LFSR seed; value 0 SHALL be replaced by 8'h01.
REQ-004 Port: clk, input, 1, single clock, all state updates on rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-high reset.
REQ-006 Port: start, input, 1, request, active low: 0 = launch job, 1 = release/idle.
REQ-007 Port: pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin, pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin, input, 8 each, 3x3 window with the centre pixel omitted.
REQ-008 Port: z_bin, output, 8, binary gradient magnitude, registered.
REQ-009 Port: done, output, 1, result valid, registered.

Function
REQ-010 States SHALL be IDLE, RUN and DONE.
REQ-011 IDLE -> RUN on the edge where start==0:
  - latch all 8 pixels;
  - load LFSR_R=SEED_R and LFSR_S=SEED_S;
  - clear ones-counter and cycle-counter.
REQ-012 Pixel inputs SHALL be ignored outside the launch edge; changes during RUN/DONE have no effect.
REQ-013 LFSRs: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting once per RUN cycle, period 255, never zero.
REQ-014 Per RUN cycle, stream bit for latched pixel p is (p > LFSR_R), unsigned; all pixels share the same LFSR_R value (correlated streams).
REQ-015 Mux select is sel = LFSR_S[1:0].
REQ-016 DIR=0: A = {p3,p6,p6,p9}[sel], B = {p1,p4,p4,p7}[sel].
REQ-017 DIR=1: A = {p7,p8,p8,p9}[sel], B = {p1,p2,p2,p3}[sel].
REQ-018 Output stream bit = A XOR B (absolute difference); the 9-bit ones-counter increments when the bit is 1.
REQ-019 RUN lasts exactly 256 cycles (cycle-counter 0..255); the LFSR sequence wraps once, repeating the seed value in the 256th cycle.
REQ-020 RUN -> DONE after the 256th cycle: z_bin = min(count, 255) (saturate 256 to 255); done=1.
REQ-021 Latency: done rises on the 257th rising edge after the launch edge.
REQ-022 In DONE, done and z_bin SHALL hold while start==0.
REQ-023 DONE -> IDLE on the edge where start==1: done=0; z_bin holds its last value.
REQ-024 start held at 0 across the DONE->IDLE boundary SHALL NOT relaunch; a new launch requires start==1 observed in IDLE or DONE, then start==0 in IDLE.
REQ-025 start toggling during RUN SHALL be ignored; the job always completes.
REQ-026 Results are deterministic for given pixels and seeds; no state carries over between jobs.

Reset
REQ-027 On reset assertion, immediately and asynchronously: state=IDLE, done=0, z_bin=0, counters=0, LFSR_R=SEED_R, LFSR_S=SEED_S, latched pixels=0.
REQ-028 Reset during RUN or DONE SHALL abort the job with no done pulse; after release, the first job requires a start 1->0 sequence.
REQ-029 Reset release is synchronous-safe: no state change on the release edge unless the launch condition holds.

Verification
REQ-030 DIR=0, all eight pixels = 8'h5A, start 1->0 -> done at edge 257, z_bin = 0.
REQ-031 DIR=0, p3=p6=p9=255, p1=p4=p7=0, default seeds -> z_bin = 255; swapping the two sides -> z_bin = 255.
REQ-032 DIR=0, p3=p6=p9=128, left column 0, default seeds -> z_bin = 128.
REQ-033 DIR=1, p7=p8=p9=128, p1=p2=p3=0, other pixels arbitrary -> z_bin = 128; the same pixels with DIR=0 and p1=p3, p7=p9 column-matched -> z_bin = 0.
REQ-034 Handshake: hold start=0 after done -> done stays 1 and no relaunch; raise start -> done=0 next edge; lower start -> new job, done after 257 edges.
REQ-035 Assert reset at RUN cycle 100 -> done=0 and z_bin=0 immediately; no done pulse; the next full job matches the reference model.
